// File: rtl/max_bus_pkg.sv
// Shared types and memory-map constants for the Commodore MAX bus decoder.
// Regions are matched on address bits [15:10] as (A & MASK) == BASE.
package max_bus_pkg;

    typedef enum logic [1:0] {
        ST_PHI1,
        ST_SETUP,
        ST_ACTIVE,
        ST_HOLD
    } state_e;

    typedef enum logic [2:0] {
        RG_RAM,
        RG_EXRAM,
        RG_ROML,
        RG_ROMH,
        RG_VIC,
        RG_SID,
        RG_COLRAM,
        RG_CIA
    } region_e;

    localparam int NUM_REGIONS = 8;

    localparam logic [5:0] RAM_BASE    = 6'b000000;
    localparam logic [5:0] RAM_MASK    = 6'b111110;
    localparam logic [5:0] EXRAM_BASE  = 6'b000010;
    localparam logic [5:0] EXRAM_MASK  = 6'b111110;
    localparam logic [5:0] ROML_BASE   = 6'b100000;
    localparam logic [5:0] ROML_MASK   = 6'b111000;
    localparam logic [5:0] ROMH_BASE   = 6'b111000;
    localparam logic [5:0] ROMH_MASK   = 6'b111000;
    localparam logic [5:0] VIC_BASE    = 6'b110100;
    localparam logic [5:0] SID_BASE    = 6'b110101;
    localparam logic [5:0] COLRAM_BASE = 6'b110110;
    localparam logic [5:0] CIA_BASE    = 6'b110111;
    localparam logic [5:0] IO_MASK     = 6'b111111;

    function automatic logic in_region(input logic [5:0] a, input logic [5:0] base,
                                       input logic [5:0] mask);
        return (a & mask) == base;
    endfunction

endpackage

// File: rtl/max_region_decode.sv
// Combinational map of A[15:10] and BA onto a one-hot region vector.
// During VIC DMA only the colour-RAM window may survive, and only when enabled.
module max_region_decode
    import max_bus_pkg::*;
#(
    parameter bit EXRAM_EN      = 1'b1,
    parameter bit COLRAM_ON_DMA = 1'b1
) (
    input  logic [5:0]             a,
    input  logic                   ba,
    output logic [NUM_REGIONS-1:0] region
);

    logic [NUM_REGIONS-1:0] hit;

    always_comb begin
        hit             = '0;
        hit[RG_RAM]     = in_region(a, RAM_BASE, RAM_MASK);
        hit[RG_EXRAM]   = EXRAM_EN && in_region(a, EXRAM_BASE, EXRAM_MASK);
        hit[RG_ROML]    = in_region(a, ROML_BASE, ROML_MASK);
        hit[RG_ROMH]    = in_region(a, ROMH_BASE, ROMH_MASK);
        hit[RG_VIC]     = in_region(a, VIC_BASE, IO_MASK);
        hit[RG_SID]     = in_region(a, SID_BASE, IO_MASK);
        hit[RG_COLRAM]  = in_region(a, COLRAM_BASE, IO_MASK);
        hit[RG_CIA]     = in_region(a, CIA_BASE, IO_MASK);

        region = '0;
        if (ba) begin
            region = hit;
        end else if (COLRAM_ON_DMA) begin
            region[RG_COLRAM] = hit[RG_COLRAM];
        end
    end

endmodule

// File: rtl/max_bus_decoder.sv
// Phase-aware chip-select sequencer for the MAX memory map: latches the decode at
// PHI2 rise and drives registered active-low selects with setup/hold timing.
module max_bus_decoder
    import max_bus_pkg::*;
#(
    parameter int SETUP_CYC     = 1,
    parameter int HOLD_CYC      = 1,
    parameter int WR_CYC        = 2,
    parameter bit EXRAM_EN      = 1'b1,
    parameter bit COLRAM_ON_DMA = 1'b1,
    parameter int TIMEOUT       = 255
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PHI2,
    input  logic [5:0] A,
    input  logic       BA,
    input  logic       RW_IN,
    output logic       RAM_N,
    output logic       EXRAM_N,
    output logic       ROML_N,
    output logic       ROMH_N,
    output logic       VIC_N,
    output logic       SID_N,
    output logic       COLRAM_N,
    output logic       CIA_N,
    output logic       BUF,
    output logic       RW_N,
    output logic       UNMAPPED,
    output logic       STALL
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_PRE  = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      SETUP_C = 4'(SETUP_CYC);
    localparam logic [3:0]      HOLD_C  = 4'(HOLD_CYC);
    localparam logic [4:0]      WR_C    = 5'(WR_CYC);

    state_e                 state, state_next;
    logic [3:0]             cnt, cnt_next;
    logic                   went_active, went_active_next;
    logic                   latch;
    logic                   phi2_prev, rise, fall, phi2_edge;
    logic [WD_W-1:0]        wd;
    logic                   timeout_now;
    logic [NUM_REGIONS-1:0] region_dec;

    logic [NUM_REGIONS-1:0] region_p0;
    logic                   ba_p0, rw_p0;

    logic [NUM_REGIONS-1:0] sel_next, sel_p1;
    logic                   rw_n_next, rw_n_p1, unmapped_next, unmapped_p1, stall_p1;

    max_region_decode #(
        .EXRAM_EN      (EXRAM_EN),
        .COLRAM_ON_DMA (COLRAM_ON_DMA)
    ) u_decode (
        .a      (A),
        .ba     (BA),
        .region (region_dec)
    );

    assign rise        = PHI2 & ~phi2_prev;
    assign fall        = ~PHI2 & phi2_prev;
    assign phi2_edge   = rise | fall;
    assign timeout_now = ~phi2_edge && (wd == WD_PRE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            phi2_prev <= 1'b0;
            wd        <= '0;
            stall_p1  <= 1'b0;
        end else begin
            phi2_prev <= PHI2;
            if (phi2_edge) begin
                wd       <= '0;
                stall_p1 <= 1'b0;
            end else if (timeout_now) begin
                wd       <= WD_MAX;
                stall_p1 <= 1'b1;
            end else if (wd != WD_MAX) begin
                wd <= wd + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_PHI1;
            cnt         <= '0;
            went_active <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            went_active <= went_active_next;
        end
    end

    // Latch stage: decode captured at PHI2 rise, held for the whole bus cycle
    always_ff @(posedge CLK) begin
        if (latch) begin
            region_p0 <= region_dec;
            ba_p0     <= BA;
            rw_p0     <= RW_IN;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        went_active_next = went_active;
        latch            = 1'b0;
        case (state)
            ST_PHI1: begin
                if (rise) begin
                    state_next       = ST_SETUP;
                    cnt_next         = 4'd1;
                    went_active_next = 1'b0;
                    latch            = 1'b1;
                end
            end
            ST_SETUP: begin
                if (fall) begin
                    state_next = (HOLD_CYC == 0) ? ST_PHI1 : ST_HOLD;
                    cnt_next   = '0;
                end else if (cnt == SETUP_C) begin
                    state_next = ST_ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            ST_ACTIVE: begin
                went_active_next = 1'b1;
                if (fall) begin
                    state_next = (HOLD_CYC == 0) ? ST_PHI1 : ST_HOLD;
                    cnt_next   = '0;
                end else if (cnt != 4'hF) begin
                    // cnt doubles as the write-strobe length counter here
                    cnt_next = cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                if (rise) begin
                    state_next       = ST_SETUP;
                    cnt_next         = 4'd1;
                    went_active_next = 1'b0;
                    latch            = 1'b1;
                end else if (cnt == HOLD_C) begin
                    state_next = ST_PHI1;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            default: state_next = ST_PHI1;
        endcase
        if (timeout_now) begin
            state_next = ST_PHI1;
            cnt_next   = '0;
        end
    end

    always_comb begin
        sel_next      = '0;
        rw_n_next     = 1'b1;
        unmapped_next = 1'b0;
        if (state == ST_ACTIVE) begin
            sel_next = region_p0;
            if (ba_p0 && !rw_p0 && (|region_p0) && ({1'b0, cnt} < WR_C)) begin
                rw_n_next = 1'b0;
            end
            if (ba_p0 && !(|region_p0) && (cnt == 4'd0)) begin
                unmapped_next = 1'b1;
            end
        end else if (state == ST_HOLD && went_active) begin
            sel_next = region_p0;
        end
        if (timeout_now) begin
            sel_next      = '0;
            rw_n_next     = 1'b1;
            unmapped_next = 1'b0;
        end
    end

    // Output stage: every pin changes one CLK after the state that drives it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel_p1      <= '0;
            rw_n_p1     <= 1'b1;
            unmapped_p1 <= 1'b0;
        end else begin
            sel_p1      <= sel_next;
            rw_n_p1     <= rw_n_next;
            unmapped_p1 <= unmapped_next;
        end
    end

    assign RAM_N    = ~sel_p1[RG_RAM];
    assign EXRAM_N  = ~sel_p1[RG_EXRAM];
    assign ROML_N   = ~sel_p1[RG_ROML];
    assign ROMH_N   = ~sel_p1[RG_ROMH];
    assign VIC_N    = ~sel_p1[RG_VIC];
    assign SID_N    = ~sel_p1[RG_SID];
    assign COLRAM_N = ~sel_p1[RG_COLRAM];
    assign CIA_N    = ~sel_p1[RG_CIA];
    assign BUF      = sel_p1[RG_COLRAM];
    assign RW_N     = rw_n_p1;
    assign UNMAPPED = unmapped_p1;
    assign STALL    = stall_p1;

endmodule
